// File: rtl/deint_pkg.sv
// deint_pkg: shared types and geometry helpers for deinterleaver_m0.
package deint_pkg;
  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;
  localparam int DEF_BRANCHES = 12;
  localparam int DEF_DEPTH_UNIT = 17;
  function automatic int branch_len(int j, int branches, int unit);
    return (branches - 1 - j) * unit;
  endfunction
  function automatic int base_addr(int j, int branches, int unit);
    int s;
    s = 0;
    for (int k = 0; k < branches; k++) if (k < j) s += branch_len(k, branches, unit);
    return s;
  endfunction
  function automatic int ram_depth(int branches, int unit);
    return base_addr(branches - 1, branches, unit);
  endfunction
  function automatic int prime_len(int branches, int unit);
    return (branches - 1) * branches * unit;
  endfunction
  localparam int RAM_DEPTH = ram_depth(DEF_BRANCHES, DEF_DEPTH_UNIT);
  localparam int PRIME_LEN = prime_len(DEF_BRANCHES, DEF_DEPTH_UNIT);
endpackage

// File: rtl/deint_branch_ram.sv
// deint_branch_ram: simple dual-port RAM, synchronous read-first, shared by all delay branches.
module deint_branch_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 1122,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/deinterleaver_m0.sv
// deinterleaver_m0: convolutional byte deinterleaver with sync-aligned commutator.
// Optional DEINT_PRIME_SKIP_EN suppresses output bytes until the delay lines are primed.
module deinterleaver_m0
  import deint_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BRANCHES = 12,
  parameter int DEPTH_UNIT = 17,
  parameter int PKT_LEN = 204,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 8'h47,
  parameter int MISS_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              upstream_rdy,
  output logic              upstream_acpt,
  input  logic [DATA_W-1:0] upstream_data,
  output logic              downstream_rdy,
  input  logic              downstream_acpt,
  output logic [DATA_W-1:0] downstream_data,
  output logic              sync_lock,
  output logic              primed
);
  localparam int DEPTH = ram_depth(BRANCHES, DEPTH_UNIT);
  localparam int PRIME = prime_len(BRANCHES, DEPTH_UNIT);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(branch_len(0, BRANCHES, DEPTH_UNIT) + 1);
  localparam int BR_W = $clog2(BRANCHES);
  localparam int PC_W = $clog2(PRIME + 1);
  localparam int PK_W = $clog2(PKT_LEN);
  localparam int MC_W = $clog2(MISS_LIMIT + 1);

  state_t            state;
  logic [BR_W-1:0]   br;
  logic [PTR_W-1:0]  ptr [BRANCHES];
  logic [PC_W-1:0]   prime_cnt;
  logic [PK_W-1:0]   pkt_cnt;
  logic [MC_W-1:0]   miss_cnt;
  logic              out_live, out_byp;
  logic [DATA_W-1:0] byp_q, ram_q;
  logic [ADDR_W-1:0] base [BRANCHES];
  logic [PTR_W-1:0]  last [BRANCHES];
  logic [ADDR_W-1:0] addr;
  logic [PTR_W-1:0]  cur;
  logic              acc, hit, chk, lose, take, byp, is_primed, emit;

  for (genvar i = 0; i < BRANCHES; i++) begin : g_geom
    assign base[i] = ADDR_W'(base_addr(i, BRANCHES, DEPTH_UNIT));
    assign last[i] = PTR_W'(branch_len(i, BRANCHES, DEPTH_UNIT) - 1);
  end

  assign upstream_acpt = !downstream_rdy || downstream_acpt;
  assign acc = upstream_rdy && upstream_acpt;
  assign hit = upstream_data == SYNC_BYTE;
  assign chk = state == RUN && pkt_cnt == '0;
  // the byte that exhausts the miss budget is dropped, not written
  assign lose = chk && !hit && miss_cnt == MC_W'(MISS_LIMIT - 1);
  assign take = acc && (state == RUN ? !lose : hit);
  assign byp = br == BR_W'(BRANCHES - 1);
  assign cur = ptr[br];
  assign addr = base[br] + ADDR_W'(cur);
  assign is_primed = prime_cnt == PC_W'(PRIME);
  assign primed = is_primed;
  assign sync_lock = state == RUN;
  assign downstream_data = out_live ? (out_byp ? byp_q : ram_q) : '0;
`ifdef DEINT_PRIME_SKIP_EN
  assign emit = is_primed;
`else
  assign emit = 1'b1;
`endif

  deint_branch_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .wr_en(take && !byp),
    .wr_addr(addr),
    .wr_data(upstream_data),
    .rd_en(take && !byp),
    .rd_addr(addr),
    .rd_data(ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HUNT;
      br <= '0;
      for (int i = 0; i < BRANCHES; i++) ptr[i] <= '0;
      prime_cnt <= '0;
      pkt_cnt <= '0;
      miss_cnt <= '0;
      downstream_rdy <= 1'b0;
      out_live <= 1'b0;
      out_byp <= 1'b0;
      byp_q <= '0;
    end else begin
      if (take) begin
        downstream_rdy <= emit;
        out_live <= is_primed;
        out_byp <= byp;
        byp_q <= upstream_data;
      end else if (downstream_acpt) downstream_rdy <= 1'b0;
      if (acc && lose) begin
        state <= HUNT;
        br <= '0;
        for (int i = 0; i < BRANCHES; i++) ptr[i] <= '0;
        prime_cnt <= '0;
        pkt_cnt <= '0;
        miss_cnt <= '0;
      end else if (take) begin
        state <= RUN;
        br <= byp ? '0 : br + 1'b1;
        if (!byp) ptr[br] <= cur == last[br] ? '0 : cur + 1'b1;
        if (!is_primed) prime_cnt <= prime_cnt + 1'b1;
        pkt_cnt <= pkt_cnt == PK_W'(PKT_LEN - 1) ? '0 : pkt_cnt + 1'b1;
        if (chk) miss_cnt <= hit ? '0 : miss_cnt + 1'b1;
      end
    end
  end
endmodule
